store_unit: RTL and testbench

Store-path counterpart of the load extension logic: it takes an `sb`/`sh`/`sw` request from the multi-cycle control FSM and places rs2 data into the correct byte lanes. It generates byte enables, detects misaligned addresses and drives a request/acknowledge data-memory port. It sits between the datapath (ALU address, rs2) and data memory. Optionally it performs read-modify-write for sub-word stores on word-only memories.

---
 rtl/store_unit_pkg.sv | 48 ++++
 rtl/store_align.sv | 46 ++++
 rtl/store_unit.sv | 130 +++++++++++++
 tb/tb_store_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/store_unit_pkg.sv
// Shared types and constants for the store path.
// STORE_RMW_EN adds the READ state and the sub-word merge helper.
package store_unit_pkg;

  typedef enum logic [1:0] {
    sb = 2'd0,
    sh = 2'd1,
    sw = 2'd2
  } Storetype;

`ifdef STORE_RMW_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
`endif

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

`ifdef STORE_RMW_EN
  // Enabled lanes keep the new store data, the rest keep what memory held.
  function automatic logic [31:0] merge_word(input logic [31:0] placed,
                                             input logic [31:0] rdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? placed[8*i +: 8] : rdata[8*i +: 8];
    end
    return res;
  endfunction
`endif

endpackage

// File: rtl/store_align.sv
// Combinational lane placement for sb/sh/sw: lane data, byte enables and
// misalignment (undefined store types are reported as misaligned).
module store_align
  import store_unit_pkg::*;
(
  input  Storetype    storetype,
  input  logic [1:0]  offset,
  input  logic [31:0] WriteData,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_be,
  output logic        misaligned
);

  always_comb begin
    lane_data  = '0;
    lane_be    = '0;
    misaligned = 1'b0;
    case (storetype)
      sb: begin
        lane_be   = BE_BYTE0 << offset;
        lane_data = {24'b0, WriteData[7:0]} << {offset, 3'b000};
      end
      sh: begin
        if (offset[0]) begin
          misaligned = 1'b1;
        end else if (offset[1]) begin
          lane_be   = BE_HALF_HI;
          lane_data = {WriteData[15:0], 16'b0};
        end else begin
          lane_be   = BE_HALF_LO;
          lane_data = {16'b0, WriteData[15:0]};
        end
      end
      sw: begin
        if (offset != 2'b00) begin
          misaligned = 1'b1;
        end else begin
          lane_be   = BE_WORD;
          lane_data = WriteData;
        end
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: places rs2 into byte lanes and runs a req/ack memory write.
// STORE_RMW_EN: sub-word stores read the word first and write back a merged word.
module store_unit
  import store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  Storetype    storetype,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic        Misaligned,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  // state | meaning
  // IDLE  | waiting for Start; request fields latched on acceptance
  // READ  | RMW only: reading the target word to merge into
  // WRITE | write request held until MemAck
  // DONE  | one-cycle Done pulse, Misaligned if the request was rejected

  state_t      state, state_nxt;
  logic        mis_q;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;
  logic        align_mis;
  logic        accept;

  store_align u_align (
    .storetype  (storetype),
    .offset     (Addr[1:0]),
    .WriteData  (WriteData),
    .lane_data  (lane_data),
    .lane_be    (lane_be),
    .misaligned (align_mis)
  );

  assign accept = (state == IDLE) && Start;

`ifdef STORE_RMW_EN
  logic [3:0]  lane_be_q;
  logic [31:0] merged;

  assign merged = merge_word(MemWData, MemRData, lane_be_q);
`else
  logic unused_rdata;
  assign unused_rdata = ^MemRData;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mis_q    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      MemBE    <= '0;
`ifdef STORE_RMW_EN
      lane_be_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        mis_q    <= align_mis;
        MemAddr  <= {Addr[31:2], 2'b00};
        MemWData <= lane_data;
`ifdef STORE_RMW_EN
        MemBE     <= BE_WORD;
        lane_be_q <= lane_be;
`else
        MemBE    <= lane_be;
`endif
      end
`ifdef STORE_RMW_EN
      else if ((state == READ) && MemAck) begin
        MemWData <= merged;
      end
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    Busy       = (state != IDLE);
    Done       = 1'b0;
    Misaligned = 1'b0;
    MemReq     = 1'b0;
    MemWe      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (align_mis) begin
            state_nxt = DONE;
`ifdef STORE_RMW_EN
          end else if (storetype != sw) begin
            state_nxt = READ;
`endif
          end else begin
            state_nxt = WRITE;
          end
        end
      end
`ifdef STORE_RMW_EN
      READ: begin
        MemReq = 1'b1;
        if (MemAck) state_nxt = WRITE;
      end
`endif
      WRITE: begin
        MemReq = 1'b1;
        MemWe  = 1'b1;
        if (MemAck) state_nxt = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        Misaligned = mis_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit; expectations follow STORE_RMW_EN when defined.
module tb_store_unit;
  import store_unit_pkg::*;

`ifdef STORE_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif
  localparam int SUB_LAT = RMW ? 3 : 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  Storetype    storetype;
  logic [31:0] Addr, WriteData, MemRData, MemAddr, MemWData;
  logic        Busy, Done, Misaligned, MemReq, MemWe, MemAck;
  logic [3:0]  MemBE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Start      (Start),
    .storetype  (storetype),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .Busy       (Busy),
    .Done       (Done),
    .Misaligned (Misaligned),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemBE      (MemBE),
    .MemRData   (MemRData),
    .MemAck     (MemAck)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one store at the current cycle (cycle 0) and acts as memory.
  task automatic run_store(input string tag, input Storetype t, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rdata, input int wait_w,
                           input bit poke, input logic exp_mis, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_be, input int exp_lat);
    int cyc, done_cyc, wcnt, unstable;
    logic mis_seen, req_seen, wr_seen;
    logic [31:0] wr_addr, wr_data;
    logic [3:0] wr_be;
    done_cyc = -1; wcnt = 0; unstable = 0;
    mis_seen = 1'b0; req_seen = 1'b0; wr_seen = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0;
    storetype = t; Addr = a; WriteData = d; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; storetype = sw; Addr = 32'hFFFF_FFFF; WriteData = 32'h5A5A_5A5A;
    cyc = 1;
    while (done_cyc < 0 && cyc < 40) begin
      MemAck = 1'b0;
      MemRData = '0;
      Start = poke && (cyc == 1);
      if (Done) begin
        done_cyc = cyc;
        mis_seen = Misaligned;
      end
      if (MemReq) req_seen = 1'b1;
      if (MemReq && MemWe) begin
        if (!wr_seen) begin
          wr_seen = 1'b1;
          wr_addr = MemAddr; wr_data = MemWData; wr_be = MemBE;
        end else if (MemAddr !== wr_addr || MemWData !== wr_data || MemBE !== wr_be) begin
          unstable++;
        end
        if (wcnt >= wait_w) MemAck = 1'b1;
        else wcnt++;
      end else if (MemReq) begin
        MemRData = rdata;
        MemAck = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    MemAck = 1'b0;
    Start = 1'b0;
    check_val({tag, " done_cycle"}, done_cyc, exp_lat);
    check_val({tag, " misaligned"}, {31'b0, mis_seen}, {31'b0, exp_mis});
    check_val({tag, " busy_after_done"}, {31'b0, Busy}, 32'd0);
    if (exp_mis) begin
      check_val({tag, " no_memreq"}, {31'b0, req_seen}, 32'd0);
    end else begin
      check_val({tag, " memaddr"}, wr_addr, {a[31:2], 2'b00});
      check_val({tag, " memwdata"}, wr_data, exp_wdata);
      check_val({tag, " membe"}, {28'b0, wr_be}, {28'b0, exp_be});
      check_val({tag, " req_stable"}, unstable, 32'd0);
    end
  endtask

  initial begin
    logic seen_done;
    reset_n = 1'b0; Start = 1'b0; storetype = sb; Addr = '0; WriteData = '0;
    MemRData = '0; MemAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("reset busy", {31'b0, Busy}, 32'd0);
    check_val("reset done", {31'b0, Done}, 32'd0);
    check_val("reset memreq", {31'b0, MemReq}, 32'd0);
    check_val("reset memaddr", MemAddr, 32'd0);
    check_val("reset memwdata", MemWData, 32'd0);
    check_val("reset membe", {28'b0, MemBE}, 32'd0);

    run_store("sb_1003", sb, 32'h1003, 32'h0000_00A5, 32'h1122_3344, 0, 1'b0, 1'b0,
              RMW ? 32'hA522_3344 : 32'hA500_0000, RMW ? 4'hF : 4'b1000, SUB_LAT);
    run_store("sh_2002", sh, 32'h2002, 32'h1234_BEEF, 32'h1122_3344, 0, 1'b0, 1'b0,
              RMW ? 32'hBEEF_3344 : 32'hBEEF_0000, RMW ? 4'hF : 4'b1100, SUB_LAT);
    run_store("sw_3001", sw, 32'h3001, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 1'b1, 32'h0, 4'h0, 1);
    run_store("sh_3003", sh, 32'h3003, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 1'b1, 32'h0, 4'h0, 1);
    run_store("sh_3001", sh, 32'h3001, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 1'b1, 32'h0, 4'h0, 1);
    run_store("undef_5000", Storetype'(2'd3), 32'h5000, 32'h1, 32'h0, 0, 1'b0, 1'b1,
              32'h0, 4'h0, 1);
    run_store("sb_4001", sb, 32'h4001, 32'h0000_00CC, 32'h1122_3344, 0, 1'b1, 1'b0,
              RMW ? 32'h1122_CC44 : 32'h0000_CC00, RMW ? 4'hF : 4'b0010, SUB_LAT);
    run_store("sh_6000", sh, 32'h6000, 32'hAAAA_5555, 32'hFFFF_FFFF, 0, 1'b0, 1'b0,
              RMW ? 32'hFFFF_5555 : 32'h0000_5555, RMW ? 4'hF : 4'b0011, SUB_LAT);
    run_store("sw_7000_wait3", sw, 32'h7000, 32'hDEAD_BEEF, 32'h0, 3, 1'b1, 1'b0,
              32'hDEAD_BEEF, 4'hF, 5);
    run_store("sb_4000", sb, 32'h4000, 32'h0000_01FF, 32'h0, 0, 1'b0, 1'b0,
              32'h0000_00FF, RMW ? 4'hF : 4'b0001, SUB_LAT);
    run_store("sb_8003_wait2", sb, 32'h8003, 32'h0000_0011, 32'h0, 2, 1'b0, 1'b0,
              RMW ? 32'h1100_0000 : 32'h1100_0000, RMW ? 4'hF : 4'b1000, SUB_LAT + 2);

    // Abort a pending request with reset; no ack is ever given.
    storetype = sb; Addr = 32'h8002; WriteData = 32'h77; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("abort memreq_before", {31'b0, MemReq}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("abort memreq", {31'b0, MemReq}, 32'd0);
    check_val("abort busy", {31'b0, Busy}, 32'd0);
    check_val("abort memaddr", MemAddr, 32'd0);
    check_val("abort membe", {28'b0, MemBE}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (4) begin
      if (Done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    check_val("abort no_done", {31'b0, seen_done}, 32'd0);

    run_store("sw_9000_post_reset", sw, 32'h9000, 32'h0BAD_F00D, 32'h0, 0, 1'b0, 1'b0,
              32'h0BAD_F00D, 4'hF, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
